// File: rtl/vctg_pkg.sv
// Shared types and helpers for the per-VC traffic generator.
package vctg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    GRANT = 2'd2
  } vctg_state_e;

  // Right-shift Galois mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] onehot(input logic [4:0] idx);
    return 32'd1 << idx;
  endfunction

  function automatic logic [7:0] max1(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

endpackage

// File: rtl/vctg_lfsr.sv
// Free-running 32-bit Galois LFSR; loads SEED on synchronous reset.
module vctg_lfsr
  import vctg_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1ACEB00C
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] o_lfsr
);

  logic [31:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (!resetn) r_lfsr <= SEED;
    else         r_lfsr <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'd0);
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/vc_traffic_gen.sv
// Per-VC packet source: one request FSM per VC and a shared flit-stream mux.
// Optional per-VC packet/flit counters when VC_TRAFFIC_GEN_STATS_EN is defined.
//   state | meaning
//   IDLE  | waiting for enable & lfsr[i]
//   REQ   | has_packet raised with dest/output_vc, awaiting cts
//   GRANT | streaming flits of the current packet
module vc_traffic_gen
  import vctg_pkg::*;
#(
  parameter int          VC_NUM     = 3,
  parameter int          PRIO_NUM   = 2,
  parameter int          OUTPUT_NUM = 8,
  parameter int          MAX_PKTS   = 4,
  parameter int          MAX_FLITS  = 8,
  parameter logic [31:0] SEED       = 32'h1ACEB00C,
  localparam int N   = VC_NUM * PRIO_NUM,
  localparam int VCW = $clog2(N),
  localparam int PW  = $clog2(MAX_PKTS + 1),
  localparam int FW  = $clog2(MAX_FLITS + 1)
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            enable,
  input  logic                            mode_fixed,
  input  logic [PW-1:0]                   cfg_pkts,
  input  logic [FW-1:0]                   cfg_flits,
  input  logic                            cts,
  input  logic [VCW-1:0]                  selected_vc,
  input  logic                            ready,
  output logic [N-1:0]                    o_has_packet,
  output logic [N-1:0][OUTPUT_NUM-1:0]    o_dest,
  output logic [N-1:0][VCW-1:0]           o_output_vc,
  output logic                            o_valid,
  output logic                            o_last,
  output logic [VCW-1:0]                  o_vc,
  output logic                            o_idle,
`ifdef VC_TRAFFIC_GEN_STATS_EN
  output logic [N-1:0][15:0]              o_pkt_cnt,
  output logic [N-1:0][15:0]              o_flit_cnt,
`endif
  output logic                            o_proto_err
);

  logic [31:0]           w_lfsr;
  logic [N-1:0]          w_req_vec;
  logic [N-1:0]          w_grant_vec;
  logic [N-1:0]          w_last_vec;
  logic                  w_any_grant;
  logic                  w_sel_req;
  logic                  w_grant_ok;
  logic                  r_proto_err;
  logic [PW-1:0]         w_fix_pkts;
  logic [PW-1:0]         w_draw_pkts;
  logic [FW-1:0]         w_fix_flits;
  logic [FW-1:0]         w_draw_flits;
  logic [OUTPUT_NUM-1:0] w_draw_dest;

  vctg_lfsr #(.SEED(SEED)) u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .o_lfsr (w_lfsr)
  );

  assign w_fix_pkts   = PW'(max1(8'(cfg_pkts)));
  assign w_fix_flits  = FW'(max1(8'(cfg_flits)));
  assign w_draw_pkts  = PW'(32'(w_lfsr[15:0]) % MAX_PKTS + 1);
  assign w_draw_flits = FW'(32'(w_lfsr[15:0]) % MAX_FLITS + 1);
  // Output 0 is never targeted, so the draw starts at 1
  assign w_draw_dest  = OUTPUT_NUM'(onehot(5'(32'(w_lfsr[31:16]) % (OUTPUT_NUM - 1) + 1)));

  always_comb begin
    w_sel_req = 1'b0;
    for (int k = 0; k < N; k++)
      if (selected_vc == VCW'(k) && w_req_vec[k]) w_sel_req = 1'b1;
  end

  assign w_any_grant = |w_grant_vec;
  assign w_grant_ok  = cts & ~w_any_grant & w_sel_req;

  // Any cts that cannot be honoured is a protocol violation
  always_ff @(posedge clk) begin
    if (!resetn)                  r_proto_err <= 1'b0;
    else if (cts && !w_grant_ok)  r_proto_err <= 1'b1;
  end

  assign o_proto_err = r_proto_err;

  for (genvar gi = 0; gi < N; gi++) begin : g_vc
    vctg_state_e           r_state, w_state_nxt;
    logic [PW-1:0]         r_pkts, w_pkts_nxt;
    logic [FW-1:0]         r_flits, w_flits_nxt;
    logic [OUTPUT_NUM-1:0] r_dest, w_dest_nxt;
    logic [VCW-1:0]        r_ovc, w_ovc_nxt;
    logic                  w_accept;
    logic                  w_last_acc;
    logic                  w_final;

    assign w_accept   = (r_state == GRANT) & ready;
    assign w_last_acc = w_accept & (r_flits == FW'(1));
    assign w_final    = w_last_acc & (r_pkts == PW'(1));

    always_ff @(posedge clk) begin
      if (!resetn) begin
        r_state <= IDLE;
        r_pkts  <= '0;
        r_flits <= '0;
        r_dest  <= '0;
        r_ovc   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_pkts  <= w_pkts_nxt;
        r_flits <= w_flits_nxt;
        r_dest  <= w_dest_nxt;
        r_ovc   <= w_ovc_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_pkts_nxt  = r_pkts;
      w_flits_nxt = r_flits;
      w_dest_nxt  = r_dest;
      w_ovc_nxt   = r_ovc;
      case (r_state)
        IDLE: begin
          if (enable && w_lfsr[gi]) begin
            w_state_nxt = REQ;
            w_pkts_nxt  = mode_fixed ? w_fix_pkts : w_draw_pkts;
            w_dest_nxt  = w_draw_dest;
            w_ovc_nxt   = VCW'(gi);
          end
        end
        REQ: begin
          if (w_grant_ok && selected_vc == VCW'(gi)) begin
            w_state_nxt = GRANT;
            w_flits_nxt = mode_fixed ? w_fix_flits : w_draw_flits;
          end
        end
        GRANT: begin
          if (w_last_acc) begin
            w_pkts_nxt = r_pkts - PW'(1);
            if (w_final) begin
              w_state_nxt = IDLE;
            end else begin
              w_state_nxt = REQ;
              w_dest_nxt  = w_draw_dest;
              w_ovc_nxt   = VCW'(gi);
            end
          end else if (w_accept) begin
            w_flits_nxt = r_flits - FW'(1);
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end

    assign w_req_vec[gi]    = (r_state == REQ);
    assign w_grant_vec[gi]  = (r_state == GRANT);
    assign w_last_vec[gi]   = (r_state == GRANT) & (r_flits == FW'(1));
    // Request drops in the same cycle the burst's final flit is taken
    assign o_has_packet[gi] = w_req_vec[gi] | (w_grant_vec[gi] & ~w_final);
    assign o_dest[gi]       = r_dest;
    assign o_output_vc[gi]  = r_ovc;

`ifdef VC_TRAFFIC_GEN_STATS_EN
    logic [15:0] r_pkt_cnt;
    logic [15:0] r_flit_cnt;

    always_ff @(posedge clk) begin
      if (!resetn) begin
        r_pkt_cnt  <= '0;
        r_flit_cnt <= '0;
      end else begin
        if (w_accept && r_flit_cnt != 16'hFFFF)   r_flit_cnt <= r_flit_cnt + 16'd1;
        if (w_last_acc && r_pkt_cnt != 16'hFFFF)  r_pkt_cnt  <= r_pkt_cnt + 16'd1;
      end
    end

    assign o_pkt_cnt[gi]  = r_pkt_cnt;
    assign o_flit_cnt[gi] = r_flit_cnt;
`else
    // Statistics counters are not built in this configuration
`endif
  end

  always_comb begin
    o_vc   = '0;
    o_last = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (w_grant_vec[k]) begin
        o_vc   = VCW'(k);
        o_last = w_last_vec[k];
      end
    end
  end

  assign o_valid = w_any_grant;
  assign o_idle  = ~|(w_req_vec | w_grant_vec);

endmodule

// File: tb/tb_vc_traffic_gen.sv
// Self-checking bench for vc_traffic_gen: directed fixed-mode cases plus a random-mode scoreboard.
module tb_vc_traffic_gen;

  localparam int N          = 6;
  localparam int VCW        = 3;
  localparam int OUTPUT_NUM = 8;
  localparam int MAX_PKTS   = 4;
  localparam int MAX_FLITS  = 8;
  localparam int PW         = 3;
  localparam int FW         = 4;

  logic                         clk = 1'b0;
  logic                         resetn = 1'b0;
  logic                         enable = 1'b0;
  logic                         mode_fixed = 1'b0;
  logic [PW-1:0]                cfg_pkts = '0;
  logic [FW-1:0]                cfg_flits = '0;
  logic                         cts = 1'b0;
  logic [VCW-1:0]               selected_vc = '0;
  logic                         ready = 1'b0;
  logic [N-1:0]                 o_has_packet;
  logic [N-1:0][OUTPUT_NUM-1:0] o_dest;
  logic [N-1:0][VCW-1:0]        o_output_vc;
  logic                         o_valid;
  logic                         o_last;
  logic [VCW-1:0]               o_vc;
  logic                         o_idle;
  logic                         o_proto_err;
`ifdef VC_TRAFFIC_GEN_STATS_EN
  logic [N-1:0][15:0]           o_pkt_cnt;
  logic [N-1:0][15:0]           o_flit_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  vc_traffic_gen dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
    .mode_fixed   (mode_fixed),
    .cfg_pkts     (cfg_pkts),
    .cfg_flits    (cfg_flits),
    .cts          (cts),
    .selected_vc  (selected_vc),
    .ready        (ready),
    .o_has_packet (o_has_packet),
    .o_dest       (o_dest),
    .o_output_vc  (o_output_vc),
    .o_valid      (o_valid),
    .o_last       (o_last),
    .o_vc         (o_vc),
    .o_idle       (o_idle),
`ifdef VC_TRAFFIC_GEN_STATS_EN
    .o_pkt_cnt    (o_pkt_cnt),
    .o_flit_cnt   (o_flit_cnt),
`endif
    .o_proto_err  (o_proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0; enable = 1'b0; cts = 1'b0; ready = 1'b0; selected_vc = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // Leaves the bench at posedge+1 with the VC in REQ and enable dropped
  task automatic wait_req(input int vc);
    bit seen = 1'b0;
    enable = 1'b1;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(posedge clk); #1;
      if (o_has_packet[vc]) seen = 1'b1;
    end
    enable = 1'b0;
    chk("wait_req", seen, 1'b1);
  endtask

  task automatic grant_vc(input int vc);
    cts = 1'b1; selected_vc = VCW'(vc);
    @(posedge clk); #1;
    cts = 1'b0;
  endtask

  task automatic test_fixed_two_pkts();
    int flits = 0;
    logic [7:0] lastmask = '0;
    bit regranted = 1'b0;
    do_reset();
    mode_fixed = 1'b1; cfg_pkts = 3'd2; cfg_flits = 4'd3; ready = 1'b1;
    wait_req(4);
    chk("t2_dest_1hot", $onehot(o_dest[4]), 1'b1);
    chk("t2_dest_bit0", o_dest[4][0], 1'b0);
    chk("t2_out_vc", o_output_vc[4], 4);
    grant_vc(4);
    cfg_pkts = 3'd4;  // already latched; burst must still be two packets
    for (int c = 0; c < 40; c++) begin
      if (flits == 3 && !regranted && !o_valid && o_has_packet[4]) begin
        chk("t2_dest2_1hot", $onehot(o_dest[4]), 1'b1);
        chk("t2_dest2_bit0", o_dest[4][0], 1'b0);
        cts = 1'b1; selected_vc = 3'd4; regranted = 1'b1;
      end else begin
        cts = 1'b0;
      end
      @(negedge clk);
      if (o_valid && ready) begin
        flits++;
        chk("t2_vc", o_vc, 4);
        if (o_last) lastmask[flits-1] = 1'b1;
        if (flits == 3) chk("t2_hp_mid", o_has_packet[4], 1'b1);
        if (flits == 6) chk("t2_hp_end", o_has_packet[4], 1'b0);
      end
      @(posedge clk); #1;
    end
    cts = 1'b0;
    chk("t2_flits", flits, 6);
    chk("t2_lasts", lastmask, 8'b0010_0100);
    chk("t2_hp_after", o_has_packet[4], 1'b0);
    chk("t2_err", o_proto_err, 1'b0);
`ifdef VC_TRAFFIC_GEN_STATS_EN
    chk("t2_pkt_cnt", o_pkt_cnt[4], 2);
    chk("t2_flit_cnt", o_flit_cnt[4], 6);
`endif
  endtask

  task automatic test_stall();
    int flits = 0;
    bit stalled = 1'b0;
    do_reset();
    mode_fixed = 1'b1; cfg_pkts = 3'd1; cfg_flits = 4'd5;
    wait_req(1);
    ready = 1'b0;
    grant_vc(1);
    for (int c = 0; c < 30; c++) begin
      ready = (c % 2 == 0);
      @(negedge clk);
      if (stalled && flits < 5) chk("t3_valid_hold", o_valid, 1'b1);
      if (o_valid) begin
        chk("t3_vc", o_vc, 1);
        chk("t3_last", o_last, flits == 4);
      end
      stalled = o_valid && !ready;
      if (o_valid && ready) flits++;
      @(posedge clk); #1;
    end
    chk("t3_flits", flits, 5);
    chk("t3_hp_after", o_has_packet[1], 1'b0);
  endtask

  task automatic test_proto();
    int flits = 0;
    // cts while VC 2 streams
    do_reset();
    mode_fixed = 1'b1; cfg_pkts = 3'd1; cfg_flits = 4'd8; ready = 1'b0;
    wait_req(2);
    grant_vc(2);
    chk("t4a_err_pre", o_proto_err, 1'b0);
    cts = 1'b1; selected_vc = 3'd2;
    @(posedge clk); #1; cts = 1'b0;
    @(negedge clk);
    chk("t4a_err", o_proto_err, 1'b1);
    chk("t4a_valid", o_valid, 1'b1);
    chk("t4a_vc", o_vc, 2);
    chk("t4a_last", o_last, 1'b0);
    @(posedge clk); #1;
    ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_valid && ready) flits++;
      @(posedge clk); #1;
    end
    chk("t4a_flits", flits, 8);
    // selected_vc out of range while a VC is requesting
    do_reset();
    chk("t4b_err_clr", o_proto_err, 1'b0);
    wait_req(0);
    cts = 1'b1; selected_vc = 3'd6;
    @(posedge clk); #1; cts = 1'b0;
    @(negedge clk);
    chk("t4b_err", o_proto_err, 1'b1);
    chk("t4b_valid", o_valid, 1'b0);
    chk("t4b_hp0", o_has_packet[0], 1'b1);
    // cts selecting an idle VC
    do_reset();
    cts = 1'b1; selected_vc = 3'd0;
    @(posedge clk); #1; cts = 1'b0;
    @(negedge clk);
    chk("t4c_err", o_proto_err, 1'b1);
    chk("t4c_valid", o_valid, 1'b0);
    chk("t4c_idle", o_idle, 1'b1);
    repeat (5) @(negedge clk);
    chk("t4c_sticky", o_proto_err, 1'b1);
  endtask

  task automatic test_random();
    int open = -1;
    int pend = -1;
    int v;
    int cand[$];
    int cur_flits[N];
    int cur_pkts[N];
    for (int k = 0; k < N; k++) begin cur_flits[k] = 0; cur_pkts[k] = 0; end
    do_reset();
    mode_fixed = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (pend >= 0) begin open = pend; pend = -1; end
      enable = ($urandom_range(3) != 0);
      ready  = ($urandom_range(3) != 0);
      cts = 1'b0;
      if (open < 0) begin
        cand.delete();
        for (int k = 0; k < N; k++) if (o_has_packet[k]) cand.push_back(k);
        if (cand.size() > 0 && $urandom_range(1) == 1) begin
          v = cand[$urandom_range(cand.size() - 1)];
          chk("t5_dest_1hot", $onehot(o_dest[v]), 1'b1);
          chk("t5_dest_bit0", o_dest[v][0], 1'b0);
          chk("t5_out_vc", o_output_vc[v], v);
          cts = 1'b1; selected_vc = VCW'(v); pend = v;
        end
      end
      @(negedge clk);
      chk("t5_valid", o_valid, open >= 0);
      if (o_valid && ready && open >= 0) begin
        chk("t5_vc", o_vc, open);
        cur_flits[open]++;
        if (o_last) begin
          chk("t5_flits_range", cur_flits[open] >= 1 && cur_flits[open] <= MAX_FLITS, 1'b1);
          cur_flits[open] = 0;
          cur_pkts[open]++;
          if (!o_has_packet[open]) begin
            chk("t5_pkts_range", cur_pkts[open] >= 1 && cur_pkts[open] <= MAX_PKTS, 1'b1);
            cur_pkts[open] = 0;
          end
          open = -1;
        end
      end
      @(posedge clk); #1;
    end
    cts = 1'b0;
    chk("t5_err", o_proto_err, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode_fixed = 1'b1; cfg_pkts = 3'd3; cfg_flits = 4'd6; ready = 1'b1;
    wait_req(0);
    grant_vc(0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_valid_pre", o_valid, 1'b1);
`ifdef VC_TRAFFIC_GEN_STATS_EN
    chk("t6_flit_cnt_pre", o_flit_cnt[0], 2);
`endif
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_hp", o_has_packet, '0);
    chk("t6_valid", o_valid, 1'b0);
    chk("t6_last", o_last, 1'b0);
    chk("t6_vc", o_vc, 0);
    chk("t6_idle", o_idle, 1'b1);
    chk("t6_err", o_proto_err, 1'b0);
    chk("t6_dest", o_dest, '0);
    chk("t6_out_vc", o_output_vc, '0);
`ifdef VC_TRAFFIC_GEN_STATS_EN
    chk("t6_pkt_cnt", o_pkt_cnt, '0);
    chk("t6_flit_cnt", o_flit_cnt, '0);
`endif
    @(posedge clk); #1 resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t1_rst_hp", o_has_packet, '0);
    chk("t1_rst_idle", o_idle, 1'b1);
    chk("t1_rst_valid", o_valid, 1'b0);
    chk("t1_rst_err", o_proto_err, 1'b0);
    @(posedge clk); #1 resetn = 1'b1; enable = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("t1_hp", o_has_packet, '0);
      chk("t1_idle", o_idle, 1'b1);
    end
    @(posedge clk); #1;
    test_fixed_two_pkts();
    test_stall();
    test_proto();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
